gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 97 +++++++++
 tb/tb_gshare_predictor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: a table of saturating counters
// indexed by the fetch PC, optionally XORed with a speculative global
// history register. Resolved branches train the table and repair the
// history after a misprediction.
`ifndef XLEN
`define XLEN 32
`endif

module gshare_predictor #(
  parameter int IDX_BITS   = 6,
  parameter int HIST_BITS  = 4,
  parameter int CTR_BITS   = 2,
  parameter int USE_GSHARE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [`XLEN-1:0]     PC,
  input  logic                 if_branch,
  output logic                 predict_taken,
  output logic [HIST_BITS-1:0] pred_ghr,
  input  logic [`XLEN-1:0]     ex_PC,
  input  logic                 ex_branch,
  input  logic                 ex_taken,
  input  logic [HIST_BITS-1:0] ex_ghr,
  input  logic                 ex_mispredict
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [CTR_BITS-1:0]  ctr_q [DEPTH];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [IDX_BITS-1:0]  fetchIdx, updIdx;
  logic [CTR_BITS-1:0]  curCtr, updCtr;
  logic                 unusedPcBits;

  // Only the word-aligned index bits of the PCs reach the table.
  assign unusedPcBits = ^{PC[`XLEN-1:IDX_BITS+2], PC[1:0],
                          ex_PC[`XLEN-1:IDX_BITS+2], ex_PC[1:0]};

  // Fetch and update indices; history folds into the low index bits
  // only in gshare mode, so bimodal mode is PC-only.
  always_comb begin
    fetchIdx = PC[IDX_BITS+1:2];
    updIdx   = ex_PC[IDX_BITS+1:2];
    if (USE_GSHARE != 0) begin
      fetchIdx = fetchIdx ^ IDX_BITS'(ghr_q);
      updIdx   = updIdx ^ IDX_BITS'(ex_ghr);
    end
  end

  // Prediction reads the pre-edge table, so the ex_* inputs never
  // reach predict_taken combinationally.
  assign predict_taken = ctr_q[fetchIdx][CTR_BITS-1];
  assign pred_ghr      = ghr_q;

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    curCtr = ctr_q[updIdx];
    updCtr = curCtr;
    if (ex_taken) begin
      if (curCtr != CTR_MAX) updCtr = curCtr + 1'b1;
    end else if (curCtr != '0) begin
      updCtr = curCtr - 1'b1;
    end
  end

  // History next state: misprediction repair beats the speculative
  // fetch shift; the cast keeps just the low bits so a 1-bit history
  // becomes the shifted-in bit alone.
  always_comb begin
    ghr_d = ghr_q;
    if (ex_branch && ex_mispredict) begin
      ghr_d = HIST_BITS'({ex_ghr, ex_taken});
    end else if (if_branch) begin
      ghr_d = HIST_BITS'({ghr_q, predict_taken});
    end
  end

  // Counter table: all entries start weakly taken; one entry trained
  // per resolving branch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (ex_branch) begin
      ctr_q[updIdx] <= updCtr;
    end
  end

  // Global history register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: three instances (gshare,
// bimodal, and a 3-bit-counter / 1-bit-history gshare) share one
// stimulus stream and are compared against an integer reference model.
`ifndef XLEN
`define XLEN 32
`endif

module tb_gshare_predictor;

  logic clock = 1'b0;
  logic reset;
  logic [`XLEN-1:0] pcR, exPcR;
  logic ifbR, exbR, extR, exmR;
  logic [3:0] exgR;

  logic predA, predB, predC;
  logic [3:0] ghrA, ghrB;
  logic [0:0] ghrC;

  typedef struct packed {
    logic [2:0] taken;
    logic [3:0] ghrA;
    logic [3:0] ghrB;
    logic [3:0] ghrC;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;

  int testsRun = 0;
  int failCount = 0;

  // Reference model state: one counter table and history per instance.
  int idxBitsM[3]  = '{6, 6, 4};
  int histBitsM[3] = '{4, 4, 1};
  int ctrBitsM[3]  = '{2, 2, 3};
  int gshareM[3]   = '{1, 0, 1};
  int ctrM[3][64];
  int ghrM[3];

  always #5 clock = ~clock;

  gshare_predictor #(.IDX_BITS(6), .HIST_BITS(4), .CTR_BITS(2), .USE_GSHARE(1)) dutA (
    .clock(clock), .reset(reset), .PC(pcR), .if_branch(ifbR),
    .predict_taken(predA), .pred_ghr(ghrA), .ex_PC(exPcR), .ex_branch(exbR),
    .ex_taken(extR), .ex_ghr(exgR), .ex_mispredict(exmR));

  gshare_predictor #(.IDX_BITS(6), .HIST_BITS(4), .CTR_BITS(2), .USE_GSHARE(0)) dutB (
    .clock(clock), .reset(reset), .PC(pcR), .if_branch(ifbR),
    .predict_taken(predB), .pred_ghr(ghrB), .ex_PC(exPcR), .ex_branch(exbR),
    .ex_taken(extR), .ex_ghr(exgR), .ex_mispredict(exmR));

  gshare_predictor #(.IDX_BITS(4), .HIST_BITS(1), .CTR_BITS(3), .USE_GSHARE(1)) dutC (
    .clock(clock), .reset(reset), .PC(pcR), .if_branch(ifbR),
    .predict_taken(predC), .pred_ghr(ghrC), .ex_PC(exPcR), .ex_branch(exbR),
    .ex_taken(extR), .ex_ghr(exgR[0:0]), .ex_mispredict(exmR));

  // Table slot a PC/history pair selects for instance k.
  function automatic int idxOf(int k, int unsigned pc, int g);
    int pcIdx;
    pcIdx = int'((pc >> 2) % (32'd1 << idxBitsM[k]));
    return (gshareM[k] != 0) ? (pcIdx ^ g) : pcIdx;
  endfunction

  // A counter in the upper half of its range predicts taken.
  function automatic bit predOf(int k, int unsigned pc);
    return ctrM[k][idxOf(k, pc, ghrM[k])] >= (1 << (ctrBitsM[k] - 1));
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++) ctrM[k][i] = 1 << (ctrBitsM[k] - 1);
      ghrM[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs now driven.
  task automatic modelStep();
    bit p[3];
    int i, c, maxc, h;
    for (int k = 0; k < 3; k++) p[k] = predOf(k, pcR);
    for (int k = 0; k < 3; k++) begin
      h = 1 << histBitsM[k];
      if (exbR) begin
        i = idxOf(k, exPcR, int'(exgR) % h);
        c = ctrM[k][i];
        maxc = (1 << ctrBitsM[k]) - 1;
        if (extR) c = (c < maxc) ? c + 1 : c;
        else      c = (c > 0) ? c - 1 : 0;
        ctrM[k][i] = c;
      end
      if (exbR && exmR)  ghrM[k] = ((int'(exgR) * 2) + int'(extR)) % h;
      else if (ifbR)     ghrM[k] = ((ghrM[k] * 2) + int'(p[k])) % h;
    end
  endtask

  function automatic exp_t expectNow();
    exp_t e;
    e.taken = {predOf(2, pcR), predOf(1, pcR), predOf(0, pcR)};
    e.ghrA  = 4'(ghrM[0]);
    e.ghrB  = 4'(ghrM[1]);
    e.ghrC  = 4'(ghrM[2]);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, queue the expected pre-edge
  // outputs, then step the model across the next edge.
  task automatic applyStimulus(input logic [`XLEN-1:0] pc, input logic ifb,
                               input logic [`XLEN-1:0] exPc, input logic exb,
                               input logic ext, input logic [3:0] exg, input logic exm);
    pcR = pc; ifbR = ifb; exPcR = exPc; exbR = exb; extR = ext; exgR = exg; exmR = exm;
    expQ.push_back(expectNow());
    @(posedge clock);
    modelStep();
    #1;
  endtask

  // Mid-cycle reset with whatever inputs are pending; they must be
  // dropped while reset is high and applied on the first edge after.
  task automatic doReset();
    #1;
    reset = 1'b1;
    modelReset();
    #1;
    expQ.push_back(expectNow());
    @(negedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    modelStep();
    #1;
  endtask

  // Monitor: the outputs are combinational, so compare whenever an
  // expectation is pending, on the falling edge.
  always @(negedge clock) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("predict_taken A", int'(predA), int'(monExp.taken[0]));
      checkOutput("predict_taken B", int'(predB), int'(monExp.taken[1]));
      checkOutput("predict_taken C", int'(predC), int'(monExp.taken[2]));
      checkOutput("pred_ghr A", int'(ghrA), int'(monExp.ghrA));
      checkOutput("pred_ghr B", int'(ghrB), int'(monExp.ghrB));
      checkOutput("pred_ghr C", int'(ghrC), int'(monExp.ghrC));
    end
  end

  initial begin
    reset = 1'b1;
    pcR = '0; exPcR = '0; ifbR = 0; exbR = 0; extR = 0; exmR = 0; exgR = '0;
    doReset();

    // Train one entry up then down to saturation.
    applyStimulus(0, 0, 0, 1, 1, 4'b0000, 0);
    for (int n = 0; n < 4; n++) applyStimulus(0, 0, 0, 1, 0, 4'b0000, 0);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0);

    // Speculative history shifts, then repair overriding a fetch shift.
    doReset();
    for (int n = 0; n < 3; n++) applyStimulus(0, 1, 0, 0, 0, 4'b0000, 0);
    applyStimulus(0, 1, 0, 1, 1, 4'b0010, 1);
    applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0);

    // Aliasing: gshare maps PC=4/GHR=1 onto the trained PC=0 entry.
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 4'b0000, 0);
    applyStimulus(0, 0, 0, 1, 0, 4'b0000, 0);
    applyStimulus(0, 0, 32'h40, 1, 1, 4'b0000, 1);
    applyStimulus(4, 0, 0, 0, 0, 4'b0000, 0);

    // Single not-taken update flips the wide counter, then reset with
    // an update still pending.
    doReset();
    applyStimulus(0, 0, 0, 1, 0, 4'b0000, 0);
    applyStimulus(0, 0, 0, 1, 0, 4'b0000, 0);
    doReset();
    applyStimulus(0, 0, 0, 0, 0, 4'b0000, 0);

    // Randomised traffic over a small PC set so entries collide.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      applyStimulus(`XLEN'($urandom_range(0, 15) << 2) | `XLEN'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    `XLEN'($urandom_range(0, 15) << 2) | `XLEN'($urandom) & `XLEN'(32'hFFFF_0000),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    #1;
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
